// File: rtl/register_file_sync.sv
// register_file_sync: MIPS general-purpose register file.
//   Two combinational read ports and one synchronous write port.
//   After reset, a clear sequencer sweeps every entry to zero, one entry
//   per clock, before writes are accepted. The array carries no per-bit
//   reset, so it can map onto FPGA distributed RAM.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high
//   reg_write  : write enable (ignored while clearing)
//   write_reg  : destination index (register-destination mux output)
//   write_data : writeback data
//   read_reg1  : source index, port 1 (rs)
//   read_reg2  : source index, port 2 (rt)
//   read_data1 : contents of read_reg1 (0 while clearing or for r0)
//   read_data2 : contents of read_reg2 (0 while clearing or for r0)
//   ready      : registered; high once the sweep is done
//
// Optional feature (macro REGFILE_WRITE_BYPASS_EN):
//   When defined, a read of the register being written in the same RUN
//   cycle returns write_data combinationally (write-before-read).
//   When undefined, reads return array contents only.
module register_file_sync #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  output logic                  ready
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int DEPTH = 1 << ADDR_WIDTH;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_regs [0:DEPTH-1];

  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_run_wr;

  // Control: state, sweep counter and ready flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
    end else if (r_state == CLEAR) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
      if (r_clr_cnt == '1) begin
        r_state <= RUN;
        r_ready <= 1'b1;
      end
    end
  end

  // A valid architectural write in RUN (r0 writes are dropped).
  assign w_run_wr = (r_state == RUN) && reg_write && (write_reg != '0);

  // Single write port shared by the sweep and the writeback path, so the
  // array keeps one write address/data pair and stays RAM-mappable.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (!reset) begin
      if (r_state == CLEAR) begin
        w_we    = 1'b1;
        w_waddr = r_clr_cnt;
        w_wdata = '0;
      end else if (w_run_wr) begin
        w_we    = 1'b1;
        w_waddr = write_reg;
        w_wdata = write_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_regs[w_waddr] <= w_wdata;
    end
  end

  // Combinational reads; zero while clearing and for r0 in every state.
  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (r_state == RUN) begin
      if (read_reg1 != '0) begin
        read_data1 = r_regs[read_reg1];
      end
      if (read_reg2 != '0) begin
        read_data2 = r_regs[read_reg2];
      end
`ifdef REGFILE_WRITE_BYPASS_EN
      if (w_run_wr && (read_reg1 == write_reg)) begin
        read_data1 = write_data;
      end
      if (w_run_wr && (read_reg2 == write_reg)) begin
        read_data2 = write_data;
      end
`endif
    end
  end

  assign ready = r_ready;

endmodule

// File: tb/tb_register_file_sync.sv
module tb_register_file_sync;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic        ready;

  int n_checks;
  int n_fail;

  register_file_sync #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .reg_write (reg_write),
    .write_reg (write_reg),
    .write_data(write_data),
    .read_reg1 (read_reg1),
    .read_reg2 (read_reg2),
    .read_data1(read_data1),
    .read_data2(read_data2),
    .ready     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic exp_ready;
    reset = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 0", ready);
    end
    n_checks++;
    if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_reads: got %h/%h expected 0/0", read_data1, read_data2);
    end
    // Release reset and attempt writes to r3 during the whole sweep.
    reset      = 1'b0;
    reg_write  = 1'b1;
    write_reg  = 5'd3;
    write_data = 32'hFFFF_FFFF;
    read_reg1  = 5'd3;
    read_reg2  = 5'd7;
    for (int i = 1; i <= 32; i++) begin
      tick();
      exp_ready = (i == 32);
      n_checks++;
      if (ready !== exp_ready) begin
        n_fail++;
        $display("FAIL sweep_ready edge %0d: got %b expected %b", i, ready, exp_ready);
      end
      if (i < 32) begin
        n_checks++;
        if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
          n_fail++;
          $display("FAIL sweep_reads edge %0d: got %h/%h expected 0/0",
                   i, read_data1, read_data2);
        end
      end
    end
    reg_write = 1'b0;
    #1;
    n_checks++;
    if (read_data1 !== 32'h0) begin
      n_fail++;
      $display("FAIL clear_write_ignored: r3 got %h expected 00000000", read_data1);
    end
  endtask

  task automatic test_write_read();
    reg_write  = 1'b1;
    write_reg  = 5'd8;
    write_data = 32'hDEAD_BEEF;
    tick();
    reg_write = 1'b0;
    read_reg1 = 5'd8;
    read_reg2 = 5'd8;
    #1;
    n_checks++;
    if (read_data1 !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL write_read_p1: got %h expected deadbeef", read_data1);
    end
    n_checks++;
    if (read_data2 !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL write_read_p2: got %h expected deadbeef", read_data2);
    end
  endtask

  task automatic test_reg0();
    reg_write  = 1'b1;
    write_reg  = 5'd0;
    write_data = 32'h1234_5678;
    read_reg1  = 5'd0;
    read_reg2  = 5'd0;
    #1;
    n_checks++;
    if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
      n_fail++;
      $display("FAIL reg0_same_cycle: got %h/%h expected 0/0", read_data1, read_data2);
    end
    tick();
    reg_write = 1'b0;
    #1;
    n_checks++;
    if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
      n_fail++;
      $display("FAIL reg0_after: got %h/%h expected 0/0", read_data1, read_data2);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_same;
`ifdef REGFILE_WRITE_BYPASS_EN
    exp_same = 32'hA5A5_A5A5;
`else
    exp_same = 32'h0000_0001;
`endif
    reg_write  = 1'b1;
    write_reg  = 5'd17;
    write_data = 32'h0000_0001;
    tick();
    write_data = 32'hA5A5_A5A5;
    read_reg1  = 5'd17;
    read_reg2  = 5'd8;
    #1;
    n_checks++;
    if (read_data1 !== exp_same) begin
      n_fail++;
      $display("FAIL same_cycle_p1: got %h expected %h", read_data1, exp_same);
    end
    n_checks++;
    if (read_data2 !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL same_cycle_p2_other: got %h expected deadbeef", read_data2);
    end
    tick();
    reg_write = 1'b0;
    read_reg2 = 5'd17;
    #1;
    n_checks++;
    if (read_data1 !== 32'hA5A5_A5A5 || read_data2 !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL same_cycle_next: got %h/%h expected a5a5a5a5/a5a5a5a5",
               read_data1, read_data2);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    reg_write = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      write_reg  = 5'(i);
      write_data = i * 32'h0101_0101;
      tick();
    end
    reg_write = 1'b0;
    read_reg1 = 5'd31;
    read_reg2 = 5'd5;
    #1;
    n_checks++;
    if (read_data1 !== 32'h1F1F_1F1F || read_data2 !== 32'h0505_0505) begin
      n_fail++;
      $display("FAIL fill_readback: got %h/%h expected 1f1f1f1f/05050505",
               read_data1, read_data2);
    end
    reset      = 1'b1;
    reg_write  = 1'b1;
    write_reg  = 5'd5;
    write_data = 32'hCAFE_BABE;
    tick();
    reset     = 1'b0;
    reg_write = 1'b0;
    #1;
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_ready: got %b expected 0", ready);
    end
    n_checks++;
    if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_reads: got %h/%h expected 0/0", read_data1, read_data2);
    end
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (ready === 1'b1) begin
        n = k;
        break;
      end
    end
    n_checks++;
    if (n != 32) begin
      n_fail++;
      $display("FAIL mid_reset_sweep_len: got %0d edges expected 32 (0 = timeout)", n);
    end
    for (int r = 0; r < 32; r++) begin
      read_reg1 = 5'(r);
      read_reg2 = 5'(31 - r);
      #1;
      n_checks++;
      if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
        n_fail++;
        $display("FAIL post_sweep_zero r%0d/r%0d: got %h/%h expected 0/0",
                 r, 31 - r, read_data1, read_data2);
      end
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    reg_write  = 1'b0;
    write_reg  = '0;
    write_data = '0;
    read_reg1  = '0;
    read_reg2  = '0;
    test_reset();
    test_write_read();
    test_reg0();
    test_same_cycle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
